// File: rtl/hdmi_period_sequencer.sv
// hdmi_period_sequencer
// Raster timing and TMDS period sequencing for an HDMI source. Produces the
// pixel position, syncs, per-cycle period mode and CTL bits, plus packet
// framing strobes for the data-island packet assembler. Every output is
// registered and describes the cx/cy value presented alongside it.

module hdmi_period_sequencer #(
  parameter int H_ACTIVE     = 640,
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_WIDTH = 96,
  parameter int V_ACTIVE     = 480,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_WIDTH = 2,
  parameter bit SYNC_POL     = 1'b0,
  parameter int ISLAND_START = 652,
  parameter int NUM_PACKETS  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       island_en,
  output logic [9:0] cx,
  output logic [9:0] cy,
  output logic [2:0] mode,
  output logic [3:0] ctl,
  output logic       hsync,
  output logic       vsync,
  output logic       packet_start,
  output logic [4:0] packet_pos
);

  // Illegal timing sets are rejected at elaboration, never handled at runtime.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_err_raster_size
    $fatal(1, "H_TOTAL and V_TOTAL must fit the 10-bit position counters");
  end
  if (NUM_PACKETS < 1 || NUM_PACKETS > 18) begin : g_err_num_packets
    $fatal(1, "NUM_PACKETS must be in 1..18");
  end
  if (ISLAND_START < H_ACTIVE + 12) begin : g_err_island_start
    $fatal(1, "ISLAND_START must leave 12 control cycles after active video");
  end
  if (ISLAND_START + 12 + 32 * NUM_PACKETS + 12 > H_TOTAL - 10) begin : g_err_island_end
    $fatal(1, "data island must end 12 control cycles before the video lead-in");
  end

  // Period mode encoding shared with the TMDS channel encoders.
  localparam logic [2:0] MODE_CTRL      = 3'd0;
  localparam logic [2:0] MODE_VIDEO     = 3'd1;
  localparam logic [2:0] MODE_VID_GUARD = 3'd2;
  localparam logic [2:0] MODE_ISL_DATA  = 3'd3;
  localparam logic [2:0] MODE_ISL_GUARD = 3'd4;

  localparam logic [3:0] CTL_VIDEO_PRE  = 4'b0001;
  localparam logic [3:0] CTL_ISLAND_PRE = 4'b0101;

  // Position thresholds sized to the counters so all compares are 10-bit.
  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT       = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT       = 10'(V_ACTIVE);
  localparam logic [9:0] V_ACT_LAST  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_START    = 10'(H_SYNC_START);
  localparam logic [9:0] HS_END      = 10'(H_SYNC_START + H_SYNC_WIDTH);
  localparam logic [9:0] VS_START    = 10'(V_SYNC_START);
  localparam logic [9:0] VS_END      = 10'(V_SYNC_START + V_SYNC_WIDTH);
  localparam logic [9:0] LEAD_START  = 10'(H_TOTAL - 10);
  localparam logic [9:0] GUARD_START = 10'(H_TOTAL - 2);
  localparam logic [9:0] ISL_SAMPLE  = 10'(ISLAND_START - 1);
  localparam logic [9:0] DATA_LAST   = 10'(32 * NUM_PACKETS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_LGUARD,
    ST_DATA,
    ST_TGUARD
  } island_state_t;

  island_state_t state_q, state_d;
  logic [9:0]    cnt_q, cnt_d;      // cycle index within the current island state
  logic [9:0]    cx_d, cy_d;
  logic [2:0]    mode_d;
  logic [3:0]    ctl_d;
  logic          hsync_d, vsync_d;
  logic          packet_start_d;
  logic [4:0]    packet_pos_d;
  logic          next_line_active;

  // Raster position for the next cycle: cx wraps each line, cy on the cx wrap.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can leave one unassigned and infer a latch.
    cx_d = cx + 10'd1;
    cy_d = cy;
    if (cx == H_LAST) begin
      cx_d = '0;
      cy_d = (cy == V_LAST) ? '0 : cy + 10'd1;
    end
  end

  // Island FSM next state; island_en only matters on the cycle before ISLAND_START.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 10'd1;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (cx == ISL_SAMPLE && island_en) state_d = ST_PRE;
      end
      ST_PRE: begin
        if (cnt_q == 10'd7) begin
          state_d = ST_LGUARD;
          cnt_d   = '0;
        end
      end
      ST_LGUARD: begin
        if (cnt_q == 10'd1) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        if (cnt_q == DATA_LAST) begin
          state_d = ST_TGUARD;
          cnt_d   = '0;
        end
      end
      ST_TGUARD: begin
        if (cnt_q == 10'd1) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Next-cycle outputs derived from the next position and island state, so the registered values line up with cx/cy.
  always_comb begin
    mode_d         = MODE_CTRL;
    ctl_d          = '0;
    packet_start_d = 1'b0;
    packet_pos_d   = '0;
    hsync_d        = (cx_d >= HS_START && cx_d < HS_END) ? SYNC_POL : ~SYNC_POL;
    vsync_d        = (cy_d >= VS_START && cy_d < VS_END) ? SYNC_POL : ~SYNC_POL;
    // The line after cy is active when cy is above the last active line or is the frame's final line.
    next_line_active = (cy_d < V_ACT_LAST) || (cy_d == V_LAST);
    case (state_d)
      ST_PRE:    ctl_d = CTL_ISLAND_PRE;
      ST_LGUARD: mode_d = MODE_ISL_GUARD;
      ST_TGUARD: mode_d = MODE_ISL_GUARD;
      ST_DATA: begin
        mode_d         = MODE_ISL_DATA;
        packet_pos_d   = cnt_d[4:0];
        packet_start_d = (cnt_d[4:0] == 5'd0);
      end
      default: begin
        if (cx_d < H_ACT && cy_d < V_ACT) begin
          mode_d = MODE_VIDEO;
        end else if (next_line_active && cx_d >= GUARD_START) begin
          mode_d = MODE_VID_GUARD;
        end else if (next_line_active && cx_d >= LEAD_START) begin
          ctl_d = CTL_VIDEO_PRE;
        end
      end
    endcase
  end

  // State and output registers; reset returns to the top-left in plain control.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register here samples pre-edge values regardless of statement order.
    if (reset) begin
      cx           <= '0;
      cy           <= '0;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      mode         <= MODE_CTRL;
      ctl          <= '0;
      hsync        <= ~SYNC_POL;
      vsync        <= ~SYNC_POL;
      packet_start <= 1'b0;
      packet_pos   <= '0;
    end else begin
      cx           <= cx_d;
      cy           <= cy_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mode         <= mode_d;
      ctl          <= ctl_d;
      hsync        <= hsync_d;
      vsync        <= vsync_d;
      packet_start <= packet_start_d;
      packet_pos   <= packet_pos_d;
    end
  end

endmodule

// File: tb/tb_hdmi_period_sequencer.sv
// Bench for hdmi_period_sequencer. Three instances run in parallel from shared
// clock, reset and island_en: default 640x480 with one packet, default with
// two packets, and a small raster (active-high syncs) so whole frames, the
// vsync window and the frame wrap are covered in a short run. A behavioural
// model derives every expected output from position and island bookkeeping.

module tb_hdmi_period_sequencer;

  typedef struct {
    int h_active;
    int h_total;
    int hs_start;
    int hs_width;
    int v_active;
    int v_total;
    int vs_start;
    int vs_width;
    bit pol;
    int isl_start;
    int npk;
  } cfg_t;

  localparam int NDUT  = 3;
  localparam int NCYC  = 30000;
  localparam int MAX_FAIL = 50;

  logic clk = 1'b0;
  logic reset;
  logic island_en;

  logic [9:0] cx_o   [NDUT];
  logic [9:0] cy_o   [NDUT];
  logic [2:0] mode_o [NDUT];
  logic [3:0] ctl_o  [NDUT];
  logic       hs_o   [NDUT];
  logic       vs_o   [NDUT];
  logic       ps_o   [NDUT];
  logic [4:0] pp_o   [NDUT];

  cfg_t cfg   [NDUT];
  int   m_cx  [NDUT];
  int   m_cy  [NDUT];
  bit   m_isl [NDUT];
  bit   m_fresh [NDUT];

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hdmi_period_sequencer u_dut0 (
    .clk(clk), .reset(reset), .island_en(island_en),
    .cx(cx_o[0]), .cy(cy_o[0]), .mode(mode_o[0]), .ctl(ctl_o[0]),
    .hsync(hs_o[0]), .vsync(vs_o[0]),
    .packet_start(ps_o[0]), .packet_pos(pp_o[0])
  );

  hdmi_period_sequencer #(.NUM_PACKETS(2)) u_dut1 (
    .clk(clk), .reset(reset), .island_en(island_en),
    .cx(cx_o[1]), .cy(cy_o[1]), .mode(mode_o[1]), .ctl(ctl_o[1]),
    .hsync(hs_o[1]), .vsync(vs_o[1]),
    .packet_start(ps_o[1]), .packet_pos(pp_o[1])
  );

  hdmi_period_sequencer #(
    .H_ACTIVE(16), .H_TOTAL(100), .H_SYNC_START(30), .H_SYNC_WIDTH(10),
    .V_ACTIVE(6), .V_TOTAL(10), .V_SYNC_START(7), .V_SYNC_WIDTH(2),
    .SYNC_POL(1'b1), .ISLAND_START(28), .NUM_PACKETS(1)
  ) u_dut2 (
    .clk(clk), .reset(reset), .island_en(island_en),
    .cx(cx_o[2]), .cy(cy_o[2]), .mode(mode_o[2]), .ctl(ctl_o[2]),
    .hsync(hs_o[2]), .vsync(vs_o[2]),
    .packet_start(ps_o[2]), .packet_pos(pp_o[2])
  );

  task automatic check(input string tag, input logic [34:0] got, input logic [34:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (fields cx,cy,mode,ctl,hs,vs,ps,pp)", tag, got, exp);
    end
  endtask

  // Expected outputs straight from the period rules for one displayed position.
  function automatic logic [34:0] model_out(input cfg_t c, input int x, input int y,
                                            input bit isl, input bit fresh);
    int  mode_e = 0;
    int  ctl_e  = 0;
    bit  ps_e   = 1'b0;
    int  pp_e   = 0;
    bit  hs_e;
    bit  vs_e;
    int  off;
    int  dlen;
    if (fresh) begin
      return {10'(x), 10'(y), 3'd0, 4'd0, ~c.pol, ~c.pol, 1'b0, 5'd0};
    end
    hs_e = (x >= c.hs_start && x < c.hs_start + c.hs_width) ? c.pol : ~c.pol;
    vs_e = (y >= c.vs_start && y < c.vs_start + c.vs_width) ? c.pol : ~c.pol;
    off  = x - c.isl_start;
    dlen = 32 * c.npk;
    if (isl && off >= 0 && off < 12 + dlen) begin
      if (off < 8) ctl_e = 5;
      else if (off < 10) mode_e = 4;
      else if (off < 10 + dlen) begin
        mode_e = 3;
        pp_e   = (off - 10) % 32;
        ps_e   = (pp_e == 0);
      end else mode_e = 4;
    end else if (x < c.h_active && y < c.v_active) begin
      mode_e = 1;
    end else if ((y < c.v_active - 1 || y == c.v_total - 1) && x >= c.h_total - 10) begin
      if (x >= c.h_total - 2) mode_e = 2;
      else ctl_e = 1;
    end
    return {10'(x), 10'(y), 3'(mode_e), 4'(ctl_e), hs_e, vs_e, ps_e, 5'(pp_e)};
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then compare mid-cycle.
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < NDUT; i++) begin
      if (reset) begin
        m_fresh[i] = 1'b1;
        m_cx[i]    = 0;
        m_cy[i]    = 0;
        m_isl[i]   = 1'b0;
      end else begin
        if (m_cx[i] == cfg[i].isl_start - 1 && island_en) m_isl[i] = 1'b1;
        m_fresh[i] = 1'b0;
        m_cx[i]++;
        if (m_cx[i] == cfg[i].h_total) begin
          m_cx[i]  = 0;
          m_cy[i]  = (m_cy[i] + 1) % cfg[i].v_total;
          m_isl[i] = 1'b0;
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("dut%0d cx=%0d cy=%0d", i, m_cx[i], m_cy[i]),
            {cx_o[i], cy_o[i], mode_o[i], ctl_o[i], hs_o[i], vs_o[i], ps_o[i], pp_o[i]},
            model_out(cfg[i], m_cx[i], m_cy[i], m_isl[i], m_fresh[i]));
    end
  endtask

  initial begin
    bit did_mid_reset = 1'b0;
    cfg[0] = '{640, 800, 656, 96, 480, 525, 490, 2, 1'b0, 652, 1};
    cfg[1] = '{640, 800, 656, 96, 480, 525, 490, 2, 1'b0, 652, 2};
    cfg[2] = '{16, 100, 30, 10, 6, 10, 7, 2, 1'b1, 28, 1};
    for (int i = 0; i < NDUT; i++) begin
      m_cx[i] = 0; m_cy[i] = 0; m_isl[i] = 1'b0; m_fresh[i] = 1'b1;
    end

    reset     = 1'b1;
    island_en = 1'b0;
    step();
    step();
    reset = 1'b0;

    for (int cyc = 0; cyc < NCYC && n_fail < MAX_FAIL; cyc++) begin
      reset     = 1'b0;
      island_en = 1'($urandom_range(0, 1));
      // Line 1: guaranteed island; line 2: late pulse only, must be ignored.
      if (m_cy[0] == 1 && m_cx[0] == 651) island_en = 1'b1;
      if (m_cy[0] == 2 && m_cx[0] == 651) island_en = 1'b0;
      if (m_cy[0] == 2 && m_cx[0] == 655) island_en = 1'b1;
      // Line 3: island forced, then reset while it is in DATA at cx=670.
      if (!did_mid_reset && m_cy[0] >= 3 && m_cx[0] == 651) island_en = 1'b1;
      if (!did_mid_reset && m_cy[0] >= 3 && m_cx[0] == 670 && m_isl[0]) begin
        reset         = 1'b1;
        did_mid_reset = 1'b1;
      end
      if ($urandom_range(0, 7999) == 0) reset = 1'b1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
